// File: rtl/data_bus_bridge_pkg.sv
// Shared types, select codes, default region map and region-match helper for the data bus bridge.
package data_bus_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_RAM  = 2'd1;
   localparam logic [1:0] SEL_MMIO = 2'd2;

   localparam logic [31:0] DEF_DATA_BASE      = 32'h1001_0000;
   localparam int          DEF_DATA_SPAN_LOG2 = 16;
   localparam logic [31:0] DEF_MMIO_BASE      = 32'hFF00_0000;
   localparam int          DEF_MMIO_SPAN_LOG2 = 12;
   localparam int          DEF_TIMEOUT        = 255;

   // True when addr shares every bit above span_log2 with base.
   function automatic logic in_region(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          span_log2);
      return ((addr ^ base) >> span_log2) == 32'd0;
   endfunction

endpackage

// File: rtl/data_bus_bridge_bus_addr_decode.sv
// Combinational region decode (RAM wins on overlap) plus malformed-access check.
// Zero latency, no flow control; sel is forced to none whenever the access faults.
module bus_addr_decode
   import data_bus_bridge_pkg::*;
#(
   parameter logic [31:0] DATA_BASE      = DEF_DATA_BASE,
   parameter int          DATA_SPAN_LOG2 = DEF_DATA_SPAN_LOG2,
   parameter logic [31:0] MMIO_BASE      = DEF_MMIO_BASE,
   parameter int          MMIO_SPAN_LOG2 = DEF_MMIO_SPAN_LOG2
) (
   input  logic [31:0] iAddress,
   input  logic [3:0]  iByteEnable,
   input  logic        iWriteEnable,
   input  logic        iReadEnable,
   output logic [1:0]  oSel,
   output logic        oErr
);

   logic hit_ram;
   logic hit_mmio;

   always_comb begin
      hit_ram  = in_region(iAddress, DATA_BASE, DATA_SPAN_LOG2);
      hit_mmio = in_region(iAddress, MMIO_BASE, MMIO_SPAN_LOG2);
      oSel     = SEL_NONE;
      if (hit_ram)
         oSel = SEL_RAM;
      else if (hit_mmio)
         oSel = SEL_MMIO;
      oErr = (iReadEnable && iWriteEnable) || (iByteEnable == 4'b0000) || (oSel == SEL_NONE);
      if (oErr)
         oSel = SEL_NONE;
   end

endmodule

// File: rtl/data_bus_bridge.sv
// Turns single-cycle core data-bus strobes into a held req/ack transaction, stalling the core meanwhile.
// Latency >= 2 cycles per access (req, ack, done); faults and timeouts end in a one-cycle bus-error pulse.
module data_bus_bridge
   import data_bus_bridge_pkg::*;
#(
   parameter logic [31:0] DATA_BASE      = DEF_DATA_BASE,
   parameter int          DATA_SPAN_LOG2 = DEF_DATA_SPAN_LOG2,
   parameter logic [31:0] MMIO_BASE      = DEF_MMIO_BASE,
   parameter int          MMIO_SPAN_LOG2 = DEF_MMIO_SPAN_LOG2,
   parameter int          TIMEOUT        = DEF_TIMEOUT
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   input  logic [3:0]  iByteEnable,
   input  logic        iWriteEnable,
   input  logic        iReadEnable,
   output logic [31:0] oReadData,
   output logic        oStall,
   output logic        oBusError,
   output logic        oMemReq,
   output logic        oMemWE,
   output logic [1:0]  oMemSel,
   output logic [31:0] oMemAddr,
   output logic [31:0] oMemWData,
   output logic [3:0]  oMemBE,
   input  logic        iMemAck,
   input  logic [31:0] iMemRData
);

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state;
   logic [7:0] cnt;
   logic       access;
   logic [1:0] dec_sel;
   logic       dec_err;

   assign access = iReadEnable | iWriteEnable;

   bus_addr_decode #(
      .DATA_BASE      (DATA_BASE),
      .DATA_SPAN_LOG2 (DATA_SPAN_LOG2),
      .MMIO_BASE      (MMIO_BASE),
      .MMIO_SPAN_LOG2 (MMIO_SPAN_LOG2)
   ) u_decode (
      .iAddress     (iAddress),
      .iByteEnable  (iByteEnable),
      .iWriteEnable (iWriteEnable),
      .iReadEnable  (iReadEnable),
      .oSel         (dec_sel),
      .oErr         (dec_err)
   );

   // Stall must already be high in the cycle the core first presents the access.
   assign oStall = !iRST && (((state == ST_IDLE) && access) || (state == ST_REQ));

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         oReadData <= 32'd0;
         oBusError <= 1'b0;
         oMemReq   <= 1'b0;
         oMemWE    <= 1'b0;
         oMemSel   <= SEL_NONE;
         oMemAddr  <= 32'd0;
         oMemWData <= 32'd0;
         oMemBE    <= 4'd0;
      end else begin
         oBusError <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access) begin
                  oMemWE    <= iWriteEnable;
                  oMemSel   <= dec_sel;
                  oMemAddr  <= iAddress;
                  oMemWData <= iWriteData;
                  oMemBE    <= iByteEnable;
                  if (dec_err) begin
                     state     <= ST_ERR;
                     oBusError <= 1'b1;
                     if (!iWriteEnable)
                        oReadData <= 32'd0;
                  end else begin
                     state   <= ST_REQ;
                     oMemReq <= 1'b1;
                     cnt     <= 8'd1;
                  end
               end
            end
            ST_REQ: begin
               // Ack takes priority over a timeout landing on the same edge.
               if (iMemAck) begin
                  state   <= ST_DONE;
                  oMemReq <= 1'b0;
                  cnt     <= 8'd0;
                  if (!oMemWE)
                     oReadData <= iMemRData;
               end else if (cnt == TMO) begin
                  state     <= ST_ERR;
                  oMemReq   <= 1'b0;
                  oBusError <= 1'b1;
                  cnt       <= 8'd0;
                  if (!oMemWE)
                     oReadData <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed bench for data_bus_bridge with a short timeout of 8 cycles.
module tb_data_bus_bridge;

   logic        iCLK;
   logic        iRST;
   logic [31:0] iAddress;
   logic [31:0] iWriteData;
   logic [3:0]  iByteEnable;
   logic        iWriteEnable;
   logic        iReadEnable;
   logic [31:0] oReadData;
   logic        oStall;
   logic        oBusError;
   logic        oMemReq;
   logic        oMemWE;
   logic [1:0]  oMemSel;
   logic [31:0] oMemAddr;
   logic [31:0] oMemWData;
   logic [3:0]  oMemBE;
   logic        iMemAck;
   logic [31:0] iMemRData;

   int checks = 0;
   int errors = 0;

   data_bus_bridge #(.TIMEOUT(8)) dut (
      .iCLK         (iCLK),
      .iRST         (iRST),
      .iAddress     (iAddress),
      .iWriteData   (iWriteData),
      .iByteEnable  (iByteEnable),
      .iWriteEnable (iWriteEnable),
      .iReadEnable  (iReadEnable),
      .oReadData    (oReadData),
      .oStall       (oStall),
      .oBusError    (oBusError),
      .oMemReq      (oMemReq),
      .oMemWE       (oMemWE),
      .oMemSel      (oMemSel),
      .oMemAddr     (oMemAddr),
      .oMemWData    (oMemWData),
      .oMemBE       (oMemBE),
      .iMemAck      (iMemAck),
      .iMemRData    (iMemRData)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [3:0] be);
      iReadEnable  = re;
      iWriteEnable = we;
      iAddress     = addr;
      iWriteData   = wdat;
      iByteEnable  = be;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      iRST = 1'b1;
      iMemAck = 1'b0;
      iMemRData = 32'd0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      tick();
      tick();
      chk("rst_memreq", 32'(oMemReq), 32'd0);
      chk("rst_stall", 32'(oStall), 32'd0);
      chk("rst_rdata", oReadData, 32'd0);
      chk("rst_buserr", 32'(oBusError), 32'd0);
      chk("rst_sel", 32'(oMemSel), 32'd0);
      iRST = 1'b0;
      tick();

      // RAM read, ack in third request cycle
      drive(1'b1, 1'b0, 32'h1001_0004, 32'd0, 4'hF);
      settle();
      chk("rd_stall_n", 32'(oStall), 32'd1);
      chk("rd_req_n", 32'(oMemReq), 32'd0);
      tick();
      chk("rd_req_1", 32'(oMemReq), 32'd1);
      chk("rd_sel", 32'(oMemSel), 32'd1);
      chk("rd_we", 32'(oMemWE), 32'd0);
      chk("rd_addr", oMemAddr, 32'h1001_0004);
      chk("rd_be", 32'(oMemBE), 32'hF);
      tick();
      chk("rd_req_2", 32'(oMemReq), 32'd1);
      chk("rd_stall_2", 32'(oStall), 32'd1);
      tick();
      chk("rd_req_3", 32'(oMemReq), 32'd1);
      iMemAck = 1'b1;
      iMemRData = 32'hDEAD_BEEF;
      tick();
      iMemAck = 1'b0;
      iMemRData = 32'd0;
      settle();
      chk("rd_done_stall", 32'(oStall), 32'd0);
      chk("rd_done_req", 32'(oMemReq), 32'd0);
      chk("rd_data", oReadData, 32'hDEAD_BEEF);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      settle();
      chk("rd_idle_stall", 32'(oStall), 32'd0);

      // MMIO write, immediate ack; read data must be untouched
      drive(1'b0, 1'b1, 32'hFF00_0010, 32'h0000_00AA, 4'b0001);
      tick();
      chk("wr_req", 32'(oMemReq), 32'd1);
      chk("wr_sel", 32'(oMemSel), 32'd2);
      chk("wr_we", 32'(oMemWE), 32'd1);
      chk("wr_be", 32'(oMemBE), 32'h1);
      chk("wr_wdata", oMemWData, 32'h0000_00AA);
      chk("wr_addr", oMemAddr, 32'hFF00_0010);
      iMemAck = 1'b1;
      iMemRData = 32'h5555_5555;
      tick();
      iMemAck = 1'b0;
      settle();
      chk("wr_done_stall", 32'(oStall), 32'd0);
      chk("wr_rdata_keep", oReadData, 32'hDEAD_BEEF);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

      // Reset in the middle of a request, late ack afterwards
      drive(1'b1, 1'b0, 32'h1001_0008, 32'd0, 4'hF);
      tick();
      chk("mr_req", 32'(oMemReq), 32'd1);
      iRST = 1'b1;
      tick();
      chk("mr_req_rst", 32'(oMemReq), 32'd0);
      chk("mr_addr_rst", oMemAddr, 32'd0);
      chk("mr_sel_rst", 32'(oMemSel), 32'd0);
      chk("mr_be_rst", 32'(oMemBE), 32'd0);
      chk("mr_rdata_rst", oReadData, 32'd0);
      chk("mr_stall_rst", 32'(oStall), 32'd0);
      iRST = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      iMemAck = 1'b1;
      iMemRData = 32'h1234_5678;
      tick();
      iMemAck = 1'b0;
      chk("mr_late_ack_rdata", oReadData, 32'd0);
      chk("mr_late_ack_req", 32'(oMemReq), 32'd0);
      drive(1'b1, 1'b0, 32'h1001_0008, 32'd0, 4'hF);
      tick();
      chk("mr_again_req", 32'(oMemReq), 32'd1);
      iMemAck = 1'b1;
      tick();
      iMemAck = 1'b0;
      chk("mr_again_rdata", oReadData, 32'h1234_5678);
      chk("mr_again_stall", 32'(oStall), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

      // Unmapped read
      drive(1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
      settle();
      chk("um_stall_n", 32'(oStall), 32'd1);
      tick();
      chk("um_buserr", 32'(oBusError), 32'd1);
      chk("um_req", 32'(oMemReq), 32'd0);
      chk("um_rdata", oReadData, 32'd0);
      chk("um_stall", 32'(oStall), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      settle();
      chk("um_buserr_off", 32'(oBusError), 32'd0);

      // Ack on the same edge as the timeout wins
      drive(1'b1, 1'b0, 32'h1001_0020, 32'd0, 4'hF);
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("tie_req_8", 32'(oMemReq), 32'd1);
      iMemAck = 1'b1;
      iMemRData = 32'h0BAD_F00D;
      tick();
      iMemAck = 1'b0;
      chk("tie_buserr", 32'(oBusError), 32'd0);
      chk("tie_rdata", oReadData, 32'h0BAD_F00D);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

      // RAM read with no ack: eight request cycles then a bus error
      drive(1'b1, 1'b0, 32'h1001_FFFC, 32'd0, 4'hF);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("to_req_%0d", i), 32'(oMemReq), 32'd1);
         chk($sformatf("to_err_%0d", i), 32'(oBusError), 32'd0);
         tick();
      end
      chk("to_req_end", 32'(oMemReq), 32'd0);
      chk("to_buserr", 32'(oBusError), 32'd1);
      chk("to_rdata", oReadData, 32'd0);
      chk("to_stall", 32'(oStall), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      settle();
      chk("to_idle_err", 32'(oBusError), 32'd0);

      // Both enables high
      drive(1'b1, 1'b1, 32'h1001_0000, 32'h1, 4'hF);
      tick();
      chk("both_buserr", 32'(oBusError), 32'd1);
      chk("both_req", 32'(oMemReq), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

      // Zero byte enables
      drive(1'b1, 1'b0, 32'h1001_0000, 32'd0, 4'h0);
      tick();
      chk("be0_buserr", 32'(oBusError), 32'd1);
      chk("be0_req", 32'(oMemReq), 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      tick();
      chk("be0_idle_req", 32'(oMemReq), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
